// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan logic.
package seg_scan_ctrl_pkg;
   localparam int DIGITS   = 4;
   localparam int NIBBLE_W = 4;
   localparam int VALUE_W  = DIGITS * NIBBLE_W;
   localparam int SCAN_W   = $clog2(DIGITS);

   localparam logic [DIGITS-1:0] BLANK_ALL  = 4'b1111;
   localparam logic [DIGITS-1:0] BLANK_NONE = 4'b0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SHOW    = 2'd2
   } arb_state_t;

   // Digit i (i >= 1) is dark when it and every more significant nibble are zero;
   // digit 0 always stays lit so a zero value still shows "0".
   function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [VALUE_W-1:0] value);
      logic [DIGITS-1:0] mask;
      logic              upper_zero;
      mask       = BLANK_NONE;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (value[i*NIBBLE_W +: NIBBLE_W] == 4'h0);
         mask[i]    = upper_zero;
      end
      return mask;
   endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Message-overlay request/ack handshake between a requester and the scan controller.
interface seg_scan_ctrl_if;
   import seg_scan_ctrl_pkg::*;

   logic               msg_req;
   logic [VALUE_W-1:0] msg_value;
   logic [7:0]         msg_frames;
   logic               msg_ack;
   logic               msg_busy;

   modport master (output msg_req, output msg_value, output msg_frames,
                   input  msg_ack, input  msg_busy);
   modport slave  (input  msg_req, input  msg_value, input  msg_frames,
                   output msg_ack, output msg_busy);
endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Digit-slot prescaler, scan index, frame pulse and blink phase for a
// multiplexed display. frame_edge is the combinational "this edge wraps the
// last digit" strobe; frame_tick is its registered image.
module scan_timer
   import seg_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              rst,
   output logic [SCAN_W-1:0] scanning,
   output logic              frame_tick,
   output logic              frame_edge,
   output logic              blink_phase
);
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0]  prescaler_r;
   logic [SCAN_W-1:0] scanning_r;
   logic              frame_tick_r;
   logic [BLK_W-1:0]  blink_cnt_r;
   logic              blink_phase_r;
   logic              terminal_s;

   assign terminal_s  = (prescaler_r == PRE_W'(SCAN_DIV - 1));
   assign frame_edge  = terminal_s && (scanning_r == SCAN_W'(DIGITS - 1));
   assign scanning    = scanning_r;
   assign frame_tick  = frame_tick_r;
   assign blink_phase = blink_phase_r;

   // Advance prescaler/scan index, register the frame pulse, count frames for blink
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_r   <= {PRE_W{1'b0}};
         scanning_r    <= {SCAN_W{1'b0}};
         frame_tick_r  <= 1'b0;
         blink_cnt_r   <= {BLK_W{1'b0}};
         blink_phase_r <= 1'b0;
      end else begin
         if (terminal_s) begin
            prescaler_r <= {PRE_W{1'b0}};
            scanning_r  <= scanning_r + SCAN_W'(1);
         end else begin
            prescaler_r <= prescaler_r + PRE_W'(1);
         end
         frame_tick_r <= frame_edge;
         if (frame_edge) begin
            if (blink_cnt_r == BLK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt_r   <= {BLK_W{1'b0}};
               blink_phase_r <= ~blink_phase_r;
            end else begin
               blink_cnt_r <= blink_cnt_r + BLK_W'(1);
            end
         end
      end
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler and display-source arbiter: the live score owns the display
// by default, a timed message overlay borrows it via request/ack. Display
// value and blanking only change on frame boundaries to avoid tearing.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VALUE_W-1:0] score_in,
   input  logic               lz_blank_en,
   input  logic               blink_en,
   seg_scan_ctrl_if.slave     msg,
   output logic [SCAN_W-1:0]  scanning,
   output logic [VALUE_W-1:0] disp_value,
   output logic [DIGITS-1:0]  blank,
   output logic               frame_tick
);
   arb_state_t         state_r, state_nx;
   logic [VALUE_W-1:0] msg_value_r, msg_value_nx;
   logic [7:0]         remaining_r, remaining_nx;
   logic               msg_ack_r, msg_ack_nx;
   logic               msg_busy_r, msg_busy_nx;
   logic [VALUE_W-1:0] disp_value_r, disp_value_nx;
   logic [DIGITS-1:0]  blank_r, blank_nx;
   logic [DIGITS-1:0]  score_blank_s;
   logic               frame_edge_s;
   logic               blink_phase_s;

   scan_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_scan_timer (
      .clk         (clk),
      .rst         (rst),
      .scanning    (scanning),
      .frame_tick  (frame_tick),
      .frame_edge  (frame_edge_s),
      .blink_phase (blink_phase_s)
   );

   // Blanking applied when the score owns the display; blink overrides leading-zero
   always_comb begin
      score_blank_s = BLANK_NONE;
      if (blink_en && blink_phase_s) begin
         score_blank_s = BLANK_ALL;
      end else if (lz_blank_en) begin
         score_blank_s = lz_blank_mask(score_in);
      end else begin
         score_blank_s = BLANK_NONE;
      end
   end

   // Arbiter next state: accept overlays in IDLE, swap sources only at frame edges
   always_comb begin
      state_nx      = state_r;
      msg_value_nx  = msg_value_r;
      remaining_nx  = remaining_r;
      msg_ack_nx    = 1'b0;
      disp_value_nx = disp_value_r;
      blank_nx      = blank_r;
      case (state_r)
         IDLE: begin
            if (frame_edge_s) begin
               disp_value_nx = score_in;
               blank_nx      = score_blank_s;
            end else begin
               disp_value_nx = disp_value_r;
               blank_nx      = blank_r;
            end
            // A request coinciding with a boundary is shown at the next one
            if (msg.msg_req) begin
               msg_ack_nx   = 1'b1;
               msg_value_nx = msg.msg_value;
               remaining_nx = (msg.msg_frames == 8'd0) ? 8'd1 : msg.msg_frames;
               state_nx     = PENDING;
            end else begin
               state_nx = IDLE;
            end
         end
         PENDING: begin
            if (frame_edge_s) begin
               disp_value_nx = msg_value_r;
               blank_nx      = BLANK_NONE;
               state_nx      = SHOW;
            end else begin
               state_nx = PENDING;
            end
         end
         SHOW: begin
            if (frame_edge_s) begin
               remaining_nx = remaining_r - 8'd1;
               if (remaining_r == 8'd1) begin
                  disp_value_nx = score_in;
                  blank_nx      = score_blank_s;
                  state_nx      = IDLE;
               end else begin
                  state_nx = SHOW;
               end
            end else begin
               state_nx = SHOW;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      msg_busy_nx = (state_nx != IDLE);
   end

   // Arbiter, message latch and display registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         msg_value_r  <= {VALUE_W{1'b0}};
         remaining_r  <= 8'd0;
         msg_ack_r    <= 1'b0;
         msg_busy_r   <= 1'b0;
         disp_value_r <= {VALUE_W{1'b0}};
         blank_r      <= BLANK_NONE;
      end else begin
         state_r      <= state_nx;
         msg_value_r  <= msg_value_nx;
         remaining_r  <= remaining_nx;
         msg_ack_r    <= msg_ack_nx;
         msg_busy_r   <= msg_busy_nx;
         disp_value_r <= disp_value_nx;
         blank_r      <= blank_nx;
      end
   end

   assign msg.msg_ack  = msg_ack_r;
   assign msg.msg_busy = msg_busy_r;
   assign disp_value   = disp_value_r;
   assign blank        = blank_r;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model predicts
// scan timing, acks and displayed content; a monitor compares on DUT outputs.
module tb_seg_scan_ctrl;
   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = 4 * SCAN_DIV;

   typedef struct {
      int          edge_n;
      logic [15:0] disp;
      logic [3:0]  blank;
   } frame_exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] score_in;
   logic        lz_blank_en;
   logic        blink_en;
   logic [1:0]  scanning;
   logic [15:0] disp_value;
   logic [3:0]  blank;
   logic        frame_tick;

   seg_scan_ctrl_if ifc ();

   seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
      .clk         (clk),
      .rst         (rst),
      .score_in    (score_in),
      .lz_blank_en (lz_blank_en),
      .blink_en    (blink_en),
      .msg         (ifc),
      .scanning    (scanning),
      .disp_value  (disp_value),
      .blank       (blank),
      .frame_tick  (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // model state (written at posedge only)
   int          e        = 0;
   int          bidx     = 0;
   bit          in_reset = 1'b1;
   bit          pending  = 1'b0;
   bit          showing  = 1'b0;
   bit          busy_exp = 1'b0;
   int          end_b    = 0;
   int          n_frames = 0;
   logic [15:0] m_val    = 16'h0;
   frame_exp_t  frame_q[$];
   int          ack_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h want %0h", name, e, act, exp_v);
      end
   endtask

   function automatic logic [3:0] score_blank_exp(input logic [15:0] s, input bit lz,
                                                  input bit bl, input int b);
      logic [3:0] m;
      m = 4'b0000;
      if (bl && ((b / BLINK_FRAMES) % 2 == 1)) begin
         m = 4'b1111;
      end else if (lz) begin
         for (int i = 1; i < 4; i++) m[i] = ((s >> (4 * i)) == 16'h0);
      end
      return m;
   endfunction

   // Reference model: one evaluation per clock edge, in frame/boundary terms
   initial begin
      frame_exp_t fe;
      bit pre_idle;
      forever begin
         @(posedge clk);
         if (rst) begin
            e = 0; bidx = 0; pending = 1'b0; showing = 1'b0; busy_exp = 1'b0;
            ack_q.delete(); frame_q.delete(); in_reset = 1'b1;
         end else begin
            in_reset = 1'b0;
            e++;
            pre_idle = !pending && !showing;
            if (e % FRAME == 0) begin
               fe.edge_n = e;
               if (showing && bidx == end_b) showing = 1'b0;
               else if (pending) begin
                  pending = 1'b0; showing = 1'b1; end_b = bidx + n_frames;
               end
               if (showing) begin
                  fe.disp = m_val; fe.blank = 4'b0000;
               end else begin
                  fe.disp  = score_in;
                  fe.blank = score_blank_exp(score_in, lz_blank_en, blink_en, bidx);
               end
               frame_q.push_back(fe);
               bidx++;
            end
            if (pre_idle && ifc.msg_req) begin
               pending  = 1'b1;
               m_val    = ifc.msg_value;
               n_frames = (ifc.msg_frames == 8'd0) ? 1 : int'(ifc.msg_frames);
               ack_q.push_back(e);
            end
            busy_exp = pending || showing;
         end
      end
   end

   // Monitor: compare DUT outputs against model predictions away from the edge
   initial begin
      frame_exp_t fe;
      logic [15:0] cur_disp;
      logic [3:0]  cur_blank;
      cur_disp = 16'h0; cur_blank = 4'h0;
      forever begin
         @(negedge clk);
         if (in_reset) begin
            check("rst_scanning", 32'(scanning), 32'd0);
            check("rst_disp", 32'(disp_value), 32'd0);
            check("rst_blank", 32'(blank), 32'd0);
            check("rst_tick", 32'(frame_tick), 32'd0);
            check("rst_ack", 32'(ifc.msg_ack), 32'd0);
            check("rst_busy", 32'(ifc.msg_busy), 32'd0);
            cur_disp = 16'h0; cur_blank = 4'h0;
         end else begin
            check("scanning", 32'(scanning), 32'((e / SCAN_DIV) % 4));
            check("frame_tick", 32'(frame_tick), 32'(e % FRAME == 0));
            check("busy", 32'(ifc.msg_busy), 32'(busy_exp));
            if (frame_tick) begin
               if (frame_q.size() == 0) begin
                  check("frame_unexpected", 32'd1, 32'd0);
               end else begin
                  fe = frame_q.pop_front();
                  check("frame_edge", 32'(e), 32'(fe.edge_n));
                  check("frame_disp", 32'(disp_value), 32'(fe.disp));
                  check("frame_blank", 32'(blank), 32'(fe.blank));
                  cur_disp = fe.disp; cur_blank = fe.blank;
               end
            end else begin
               check("hold_disp", 32'(disp_value), 32'(cur_disp));
               check("hold_blank", 32'(blank), 32'(cur_blank));
            end
            if (ifc.msg_ack) begin
               if (ack_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
               else check("ack_edge", 32'(e), 32'(ack_q.pop_front()));
            end else if (ack_q.size() > 0 && ack_q[0] <= e) begin
               check("ack_missing", 32'd0, 32'd1);
               void'(ack_q.pop_front());
            end
         end
      end
   end

   // One stimulus cycle; the requester drops its level once acked
   task automatic tick();
      @(negedge clk);
      if (ifc.msg_ack) ifc.msg_req = 1'b0;
   endtask

   task automatic wait_edge(input int target);
      for (int k = 0; k < 2000 && e < target; k++) tick();
   endtask

   task automatic request(input logic [15:0] v, input logic [7:0] f);
      ifc.msg_req = 1'b1; ifc.msg_value = v; ifc.msg_frames = f;
   endtask

   task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         tick();
         if ($urandom_range(99, 0) < 5) score_in = 16'($urandom) & (($urandom_range(1, 0) == 1) ? 16'h00FF : 16'hFFFF);
         if ($urandom_range(99, 0) < 1) lz_blank_en = ~lz_blank_en;
         if ($urandom_range(99, 0) < 1) blink_en = ~blink_en;
         if (!ifc.msg_req && $urandom_range(99, 0) < 3)
            request(16'($urandom), 8'($urandom_range(3, 0)));
      end
   endtask

   initial begin
      bit hit;
      rst = 1'b1; score_in = 16'h0040; lz_blank_en = 1'b1; blink_en = 1'b0;
      ifc.msg_req = 1'b0; ifc.msg_value = 16'h0; ifc.msg_frames = 8'd0;
      repeat (3) tick();
      rst = 1'b0;
      // directed: score change mid-frame, overlays, boundary-coincident requests
      wait_edge(24);  score_in = 16'h1234;
      wait_edge(40);  request(16'hDEAD, 8'd2);
      wait_edge(56);  request(16'hBEEF, 8'd0);
      wait_edge(128); request(16'h0C0D, 8'd0);
      wait_edge(175); request(16'hF00D, 8'd1);
      wait_edge(215); blink_en = 1'b1; score_in = 16'h0007;
      wait_edge(250); request(16'h1111, 8'd2);
      wait_edge(340);
      random_phase(2000);
      // reset in the middle of a displayed overlay
      for (int k = 0; k < 300 && ifc.msg_req; k++) tick();
      request(16'hA5A5, 8'd3);
      hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         tick();
         hit = showing && (e % FRAME == 5);
      end
      check("reach_show", 32'(hit), 32'd1);
      rst = 1'b1; ifc.msg_req = 1'b0;
      tick();
      rst = 1'b0;
      random_phase(600);
      tick();
      check("acks_drained", 32'(ack_q.size()), 32'd0);
      check("frames_drained", 32'(frame_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
